// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and imem (slave),
// plus the shared next-PC select encodings.
`ifndef NPC_PLUS4
`define NPC_PLUS4  3'b000
`endif
`ifndef NPC_BRANCH
`define NPC_BRANCH 3'b001
`endif
`ifndef NPC_JUMP
`define NPC_JUMP   3'b010
`endif
`ifndef NPC_JALR
`define NPC_JALR   3'b100
`endif

interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch front end: PC, imem req/ack, one-entry hold buffer, IF/ID register.
// Optional FETCH_PERF_EN adds fetched/bubble/killed performance counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_IF,
    input  logic               flush_IF,
    input  logic [2:0]         NPCOp,
    input  logic [31:0]        NPCImm,
    input  logic [31:0]        base_PC,
    input  logic [31:0]        alu_result_EX,
    fetch_unit_if.master       imem,
    output logic [31:0]        PC_ID,
    output logic [31:0]        instr_ID,
    output logic               valid_ID,
    output logic               redirect_busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles,
    output logic [31:0]        perf_killed
`endif
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {FETCH, KILL, HELD} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
    logic [XLEN-1:0]   buf_pc_q, buf_pc_d;
    logic [XLEN-1:0]   buf_instr_q, buf_instr_d;
    logic [XLEN-1:0]   pc_id_q, pc_id_d;
    logic [XLEN-1:0]   instr_id_q, instr_id_d;
    logic              valid_id_q, valid_id_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;

    logic              redir_op;
    logic              redir;
    logic [XLEN-1:0]   target;
    logic              dlv_valid;
    logic [XLEN-1:0]   dlv_pc;
    logic [XLEN-1:0]   dlv_instr;

    // Redirect decode; unknown encodings fall back to sequential fetch.
    always_comb begin
        redir_op = 1'b0;
        target   = pc_q;
        case (NPCOp)
            `NPC_BRANCH, `NPC_JUMP: begin
                redir_op = 1'b1;
                target   = base_PC + NPCImm;
            end
            `NPC_JALR: begin
                redir_op = 1'b1;
                target   = alu_result_EX & ~XLEN'(1);
            end
            default: ;
        endcase
        redir = redir_op && !stall_IF;
    end

    // Next-state, PC and delivery selection.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_pc_d  = redir_pc_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        dlv_valid   = 1'b0;
        dlv_pc      = pc_q;
        dlv_instr   = imem.imem_rdata;

        case (state_q)
            FETCH: begin
                if (redir) begin
                    if (imem.imem_ack) begin
                        pc_d = target;
                    end else begin
                        redir_pc_d = target;
                        state_d    = KILL;
                    end
                end else if (imem.imem_ack) begin
                    pc_d = pc_q + XLEN'(4);
                    if (!stall_IF) begin
                        dlv_valid = 1'b1;
                    end else begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem.imem_rdata;
                        state_d     = HELD;
                    end
                end
            end
            KILL: begin
                // Latest redirect wins; the outstanding response is discarded.
                if (redir) redir_pc_d = target;
                if (imem.imem_ack) begin
                    pc_d    = redir ? target : redir_pc_q;
                    state_d = FETCH;
                end
            end
            HELD: begin
                if (redir) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!stall_IF) begin
                    dlv_valid = 1'b1;
                    dlv_pc    = buf_pc_q;
                    dlv_instr = buf_instr_q;
                    state_d   = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        pc_id_d    = pc_id_q;
        instr_id_d = instr_id_q;
        valid_id_d = valid_id_q;
        if (flush_IF) begin
            valid_id_d = 1'b0;
            instr_id_d = NOP_INSTR;
        end else if (!stall_IF) begin
            if (dlv_valid) begin
                valid_id_d = 1'b1;
                pc_id_d    = dlv_pc;
                instr_id_d = dlv_instr;
            end else begin
                valid_id_d = 1'b0;
                instr_id_d = NOP_INSTR;
            end
        end

        req_d  = (state_d != HELD);
        busy_d = (state_d == KILL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            redir_pc_q  <= '0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
            pc_id_q     <= '0;
            instr_id_q  <= NOP_INSTR;
            valid_id_q  <= 1'b0;
            req_q       <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redir_pc_q  <= redir_pc_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            pc_id_q     <= pc_id_d;
            instr_id_q  <= instr_id_d;
            valid_id_q  <= valid_id_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
        end
    end

    // The address stays at the stale PC in KILL because pc_q only moves on ack.
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign PC_ID          = pc_id_q;
    assign instr_ID       = instr_id_q;
    assign valid_ID       = valid_id_q;
    assign redirect_busy  = busy_q;

`ifdef FETCH_PERF_EN
    logic killed_c;
    logic fetched_c;
    logic bubble_c;

    always_comb begin
        killed_c  = imem.imem_ack &&
                    ((state_q == KILL) || ((state_q == FETCH) && redir));
        fetched_c = !flush_IF && !stall_IF && dlv_valid;
        bubble_c  = !stall_IF && (flush_IF || !dlv_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
            perf_killed  <= '0;
        end else begin
            if (fetched_c) perf_fetched <= perf_fetched + XLEN'(1);
            if (bubble_c)  perf_bubbles <= perf_bubbles + XLEN'(1);
            if (killed_c)  perf_killed  <= perf_killed + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a variable-latency imem model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall_IF;
    logic        flush_IF;
    logic [2:0]  NPCOp;
    logic [31:0] NPCImm;
    logic [31:0] base_PC;
    logic [31:0] alu_result_EX;
    logic [31:0] PC_ID;
    logic [31:0] instr_ID;
    logic        valid_ID;
    logic        redirect_busy;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
    logic [31:0] perf_killed;
`endif

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall_IF      (stall_IF),
        .flush_IF      (flush_IF),
        .NPCOp         (NPCOp),
        .NPCImm        (NPCImm),
        .base_PC       (base_PC),
        .alu_result_EX (alu_result_EX),
        .imem          (bus),
        .PC_ID         (PC_ID),
        .instr_ID      (instr_ID),
        .valid_ID      (valid_ID),
        .redirect_busy (redirect_busy)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_bubbles  (perf_bubbles),
        .perf_killed   (perf_killed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory acks after lat cycles of a held request; word = addr ^ 5A5A5A5A.
    int lat = 0;
    int mem_cnt = 0;
    assign bus.imem_ack   = bus.imem_req && (mem_cnt >= lat);
    assign bus.imem_rdata = bus.imem_addr ^ 32'h5A5A_5A5A;
    always @(posedge clk) begin
        if (bus.imem_req && !bus.imem_ack) mem_cnt <= mem_cnt + 1;
        else                               mem_cnt <= 0;
    end

    // Word at 0x64 is fetched then killed by a JALR; it must never go valid.
    logic stale_seen = 1'b0;
    always @(negedge clk) begin
        if (valid_ID && instr_ID == 32'h5A5A_5A3E) stale_seen <= 1'b1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_IF = 1'b0; flush_IF = 1'b0; NPCOp = `NPC_PLUS4;
        NPCImm = '0; base_PC = '0; alu_result_EX = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("rst_addr",  bus.imem_addr, 32'h0);
        check_eq("rst_req",   32'(bus.imem_req), 32'h1);
        check_eq("rst_valid", 32'(valid_ID), 32'h0);
        check_eq("rst_pcid",  PC_ID, 32'h0);
        check_eq("rst_instr", instr_ID, 32'h0000_0013);
        check_eq("rst_busy",  32'(redirect_busy), 32'h0);

        // Zero-wait streaming.
        tick();
        check_eq("s1_addr",  bus.imem_addr, 32'h4);
        check_eq("s1_pcid",  PC_ID, 32'h0);
        check_eq("s1_instr", instr_ID, 32'h5A5A_5A5A);
        check_eq("s1_valid", 32'(valid_ID), 32'h1);
        tick();
        check_eq("s2_addr",  bus.imem_addr, 32'h8);
        check_eq("s2_pcid",  PC_ID, 32'h4);

        // Stall two cycles while the word at 8 is acked.
        stall_IF = 1'b1;
        tick();
        check_eq("h1_req",   32'(bus.imem_req), 32'h0);
        check_eq("h1_addr",  bus.imem_addr, 32'hC);
        check_eq("h1_pcid",  PC_ID, 32'h4);
        tick();
        check_eq("h2_req",   32'(bus.imem_req), 32'h0);
        check_eq("h2_instr", instr_ID, 32'h5A5A_5A5E);
        stall_IF = 1'b0;
        tick();
        check_eq("h3_pcid",  PC_ID, 32'h8);
        check_eq("h3_instr", instr_ID, 32'h5A5A_5A52);
        check_eq("h3_req",   32'(bus.imem_req), 32'h1);
        check_eq("h3_addr",  bus.imem_addr, 32'hC);
        tick();
        check_eq("h4_pcid",  PC_ID, 32'hC);
        check_eq("h4_addr",  bus.imem_addr, 32'h10);

        // Branch with flush.
        NPCOp = `NPC_BRANCH; base_PC = 32'h4; NPCImm = 32'h10; flush_IF = 1'b1;
        tick();
        check_eq("br_addr",  bus.imem_addr, 32'h14);
        check_eq("br_valid", 32'(valid_ID), 32'h0);
        check_eq("br_instr", instr_ID, 32'h0000_0013);
        NPCOp = `NPC_PLUS4; flush_IF = 1'b0;
        tick();
        check_eq("br2_pcid",  PC_ID, 32'h14);
        check_eq("br2_instr", instr_ID, 32'h5A5A_5A4E);
        check_eq("br2_valid", 32'(valid_ID), 32'h1);

        // Jump ignored under stall, taken once released.
        lat = 2; NPCOp = `NPC_JUMP; base_PC = 32'h40; NPCImm = 32'h20; stall_IF = 1'b1;
        tick();
        check_eq("js_addr",  bus.imem_addr, 32'h18);
        check_eq("js_pcid",  PC_ID, 32'h14);
        check_eq("js_valid", 32'(valid_ID), 32'h1);
        stall_IF = 1'b0; lat = 0;
        tick();
        check_eq("jt_addr",  bus.imem_addr, 32'h60);
        check_eq("jt_valid", 32'(valid_ID), 32'h0);
        check_eq("jt_busy",  32'(redirect_busy), 32'h0);
        NPCOp = `NPC_PLUS4;
        tick();
        check_eq("jt2_pcid",  PC_ID, 32'h60);
        check_eq("jt2_instr", instr_ID, 32'h5A5A_5A3A);

        // JALR during a 3-cycle fetch: kill the in-flight word.
        lat = 3;
        tick();
        check_eq("k0_valid", 32'(valid_ID), 32'h0);
        check_eq("k0_addr",  bus.imem_addr, 32'h64);
        NPCOp = `NPC_JALR; alu_result_EX = 32'h101;
        tick();
        check_eq("k1_busy",  32'(redirect_busy), 32'h1);
        check_eq("k1_addr",  bus.imem_addr, 32'h64);
        check_eq("k1_req",   32'(bus.imem_req), 32'h1);
        NPCOp = `NPC_PLUS4;
        tick();
        check_eq("k2_busy",  32'(redirect_busy), 32'h1);
        check_eq("k2_addr",  bus.imem_addr, 32'h64);
        tick();
        check_eq("k3_busy",  32'(redirect_busy), 32'h0);
        check_eq("k3_addr",  bus.imem_addr, 32'h100);
        check_eq("k3_valid", 32'(valid_ID), 32'h0);
        lat = 0;
        tick();
        check_eq("k4_pcid",  PC_ID, 32'h100);
        check_eq("k4_instr", instr_ID, 32'h5A5A_5B5A);
        check_eq("k4_valid", 32'(valid_ID), 32'h1);

        // Asynchronous reset while in KILL.
        lat = 3; NPCOp = `NPC_JALR; alu_result_EX = 32'h201;
        tick();
        check_eq("r0_busy",  32'(redirect_busy), 32'h1);
        check_eq("r0_addr",  bus.imem_addr, 32'h104);
        NPCOp = `NPC_PLUS4;
        #2 rst = 1'b1;
        #1;
        check_eq("ar_addr",  bus.imem_addr, 32'h0);
        check_eq("ar_valid", 32'(valid_ID), 32'h0);
        check_eq("ar_busy",  32'(redirect_busy), 32'h0);
        check_eq("ar_pcid",  PC_ID, 32'h0);
        tick();
        tick();
        lat = 0; rst = 1'b0;
        #1;
        check_eq("ar2_addr", bus.imem_addr, 32'h0);
        tick();
        check_eq("ar3_pcid",  PC_ID, 32'h0);
        check_eq("ar3_valid", 32'(valid_ID), 32'h1);
        check_eq("ar3_addr",  bus.imem_addr, 32'h4);

        // Unknown NPCOp behaves as PLUS4.
        NPCOp = 3'b111; base_PC = 32'h40; NPCImm = 32'h20;
        tick();
        check_eq("unk_pcid", PC_ID, 32'h4);
        check_eq("unk_addr", bus.imem_addr, 32'h8);

        // PC wrap.
        NPCOp = `NPC_JUMP; base_PC = 32'hFFFF_FFF0; NPCImm = 32'hC;
        tick();
        check_eq("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
        NPCOp = `NPC_PLUS4;
        tick();
        check_eq("wr_pcid",  PC_ID, 32'hFFFF_FFFC);
        check_eq("wr_instr", instr_ID, 32'hA5A5_A5A6);
        check_eq("wr_addr2", bus.imem_addr, 32'h0);

        // Misaligned jump target passes through untouched.
        NPCOp = `NPC_JUMP; base_PC = 32'h200; NPCImm = 32'h2;
        tick();
        check_eq("mis_addr", bus.imem_addr, 32'h202);
        NPCOp = `NPC_PLUS4;
        tick();
        check_eq("mis_pcid",  PC_ID, 32'h202);
        check_eq("mis_instr", instr_ID, 32'h5A5A_5858);
        check_eq("mis_addr2", bus.imem_addr, 32'h206);

        check_eq("stale_word", 32'(stale_seen), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
